// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM core and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   CW_DEF / NCH_DEF  default counter width and channel count
//   NCH_MAX           largest supported channel count
//   cnt_dir_e         counter direction used by centre-aligned counting
//   shadow_t          register-map layout of one load set at default widths
package pwm_pkg;

   localparam int CW_DEF  = 16;
   localparam int NCH_DEF = 4;
   localparam int NCH_MAX = 16;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } cnt_dir_e;

   // One complete set of load fields as software sees it in the register map.
   typedef struct packed {
      logic [CW_DEF-1:0]              period;
      logic [CW_DEF-1:0]              prescaler;
      logic [NCH_DEF-1:0][CW_DEF-1:0] duty;
      logic                           center_mode;
   } shadow_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing a one-cycle tick every max(div_i,1) clocks.
// Latency: tick_o is combinational from the registered count.
// Backpressure: none; clear_i holds the count at 0 and suppresses the tick.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear_i      hold count at 0, no tick
//   div_i        divide ratio (0 and 1 both divide by 1)
//   tick_o       high on the cycle the count sits at its terminal value
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic [CW-1:0] div_i,
   output logic          tick_o
);

   logic [CW-1:0] psc_cnt_q;
   logic [CW-1:0] psc_cnt_d;
   logic [CW-1:0] term;

   assign term = (div_i > CW'(1)) ? div_i - CW'(1) : '0;

   // >= rather than == so a shrinking ratio can never strand the count
   // above the terminal value.
   assign tick_o = !clear_i && (psc_cnt_q >= term);

   always_comb begin
      psc_cnt_d = psc_cnt_q + CW'(1);
      if (clear_i || tick_o) begin
         psc_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_cnt_q <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_multi_core.sv
// N-channel PWM generator: shared prescaler and period counter, per-channel compare,
// shadowed period/prescaler/duty applied at the period boundary (or at once when disabled).
// Latency: pwm_out and period_tick are registered, one cycle behind the counter. Backpressure: none.
//
// Optional build macro PWM_CENTER_ALIGN_EN adds the center_mode input (up/down counting).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   enable          run; low clears the counters, forces outputs low, applies loads at once
//   prescaler       clock divide ratio (0/1 = divide by 1)
//   period          counts per period (0 = outputs held low)
//   duty            per-channel compare, channel i at [i*CW +: CW]
//   load            one-cycle pulse arming a shadow transfer
//   center_mode     (PWM_CENTER_ALIGN_EN only) up/down counting when set
//   load_pending    armed load still waiting for a boundary
//   pwm_out         registered channel outputs
//   period_tick     one-cycle pulse the cycle after each wrap
//   counter         active period counter
module pwm_multi_core
   import pwm_pkg::*;
#(
   parameter int CW  = CW_DEF,
   parameter int NCH = NCH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [CW-1:0]     prescaler,
   input  logic [CW-1:0]     period,
   input  logic [NCH*CW-1:0] duty,
   input  logic              load,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic              center_mode,
`endif
   output logic              load_pending,
   output logic [NCH-1:0]    pwm_out,
   output logic              period_tick,
   output logic [CW-1:0]     counter
);

   // Active (post-shadow) configuration.
   logic [CW-1:0]           period_q;
   logic [CW-1:0]           psc_q;
   logic [NCH-1:0][CW-1:0]  duty_q;

   logic                    pending_q;
   logic                    pending_d;
   logic [CW-1:0]           counter_q;
   logic [CW-1:0]           counter_d;
   logic [NCH-1:0]          pwm_q;
   logic [NCH-1:0]          pwm_d;
   logic                    period_tick_q;

   logic                    run;
   logic                    tick;
   logic                    wrap;
   logic                    pend_any;
   logic                    apply;
   logic [CW-1:0]           top_val;

`ifdef PWM_CENTER_ALIGN_EN
   logic                    cmode_q;
   cnt_dir_e                dir_q;
   cnt_dir_e                dir_d;
   logic                    center_run;

   // A one-count period cannot count down, so it falls back to edge mode.
   assign center_run = cmode_q && (period_q > CW'(1));
`endif

   // period_q - 1 is only formed when period_q is non-zero.
   assign run     = enable && (period_q != '0);
   assign top_val = run ? period_q - CW'(1) : '0;

   pwm_prescaler #(
      .CW (CW)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!run),
      .div_i   (psc_q),
      .tick_o  (tick)
   );

   always_comb begin
      counter_d = counter_q;
      wrap      = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d     = dir_q;
`endif
      if (!run) begin
         counter_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_d     = UP;
`endif
      end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
         if (center_run) begin
            if (dir_q == UP) begin
               if (counter_q >= top_val) begin
                  // Turn around below the top so the peak is not repeated;
                  // with period 2 the turn-around value is already 0.
                  counter_d = top_val - CW'(1);
                  if (counter_d == '0) begin
                     wrap = 1'b1;
                  end else begin
                     dir_d = DOWN;
                  end
               end else begin
                  counter_d = counter_q + CW'(1);
               end
            end else begin
               counter_d = counter_q - CW'(1);
               if (counter_d == '0) begin
                  wrap  = 1'b1;
                  dir_d = UP;
               end
            end
         end else
`endif
         begin
            if (counter_q >= top_val) begin
               counter_d = '0;
               wrap      = 1'b1;
            end else begin
               counter_d = counter_q + CW'(1);
            end
         end
      end
   end

   // A load arriving on the wrap cycle is applied at that same wrap; when
   // halted there is no boundary to wait for.
   assign pend_any  = pending_q || load;
   assign apply     = pend_any && (wrap || !enable);
   assign pending_d = pend_any && !apply;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign pwm_d[i] = run && (counter_q < duty_q[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period_q      <= '0;
         psc_q         <= '0;
         duty_q        <= '0;
         pending_q     <= 1'b0;
         counter_q     <= '0;
         pwm_q         <= '0;
         period_tick_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         cmode_q       <= 1'b0;
         dir_q         <= UP;
`endif
      end else begin
         pending_q     <= pending_d;
         counter_q     <= counter_d;
         pwm_q         <= pwm_d;
         period_tick_q <= wrap;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q         <= dir_d;
`endif
         if (apply) begin
            period_q <= period;
            psc_q    <= prescaler;
            duty_q   <= duty;
`ifdef PWM_CENTER_ALIGN_EN
            cmode_q  <= center_mode;
`endif
         end
      end
   end

   assign load_pending = pending_q;
   assign pwm_out      = pwm_q;
   assign period_tick  = period_tick_q;
   assign counter      = counter_q;

endmodule

// File: tb/tb_pwm_multi_core.sv
// Self-checking bench for pwm_multi_core (default edge-aligned build).
// A time-based model (clocks elapsed since the run started, divided out
// arithmetically) predicts every output each cycle; directed phases pin it.
module tb_pwm_multi_core;

   localparam int CW  = 16;
   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic [CW-1:0]     prescaler = '0;
   logic [CW-1:0]     period = '0;
   logic [NCH*CW-1:0] duty = '0;
   logic              load = 1'b0;
   logic              load_pending;
   logic [NCH-1:0]    pwm_out;
   logic              period_tick;
   logic [CW-1:0]     counter;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pwm_multi_core #(
      .CW  (CW),
      .NCH (NCH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .prescaler    (prescaler),
      .period       (period),
      .duty         (duty),
      .load         (load),
      .load_pending (load_pending),
      .pwm_out      (pwm_out),
      .period_tick  (period_tick),
      .counter      (counter)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_per, m_psc, e;
   int       m_duty[NCH];
   bit       m_pend;
   bit       chk_on = 1'b0;
   logic [NCH-1:0] x_pwm;
   bit       x_tick, x_pend;
   int       x_cnt;
   int       md, cur;
   bit       running, tk, wr, applied;

   always @(posedge clk) begin
      if (reset) begin
         m_per = 0; m_psc = 0; e = 0; m_pend = 1'b0;
         for (int i = 0; i < NCH; i++) m_duty[i] = 0;
         x_pwm = '0; x_tick = 1'b0; x_pend = 1'b0; x_cnt = 0;
         chk_on = 1'b1;
      end else begin
         md      = (m_psc <= 1) ? 1 : m_psc;
         running = enable && (m_per != 0);
         cur     = running ? (e / md) % m_per : 0;
         tk      = running && (e % md == md - 1);
         wr      = tk && (cur == m_per - 1);
         for (int i = 0; i < NCH; i++) x_pwm[i] = running && (cur < m_duty[i]);
         x_tick  = wr;
         applied = 1'b0;
         if ((m_pend || load) && (wr || !enable)) begin
            m_per = int'(period);
            m_psc = int'(prescaler);
            for (int i = 0; i < NCH; i++) m_duty[i] = int'(duty[i*CW +: CW]);
            m_pend  = 1'b0;
            applied = 1'b1;
            e       = 0;
         end else begin
            m_pend = m_pend || load;
            e      = running ? e + 1 : 0;
         end
         x_pend = m_pend;
         x_cnt  = (running && !applied) ? (e / md) % m_per : 0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("pwm_out", 32'(pwm_out), 32'(x_pwm));
         check("period_tick", 32'(period_tick), 32'(x_tick));
         check("counter", 32'(counter), 32'(x_cnt));
         check("load_pending", 32'(load_pending), 32'(x_pend));
      end
   end

   // ---------------- directed helpers ----------------
   int w_hi[NCH];
   int w_ticks, w_gap;

   task automatic window(input int n);
      int last;
      last = -1;
      w_ticks = 0; w_gap = 0;
      for (int i = 0; i < NCH; i++) w_hi[i] = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) if (pwm_out[i]) w_hi[i]++;
         if (period_tick) begin
            if (last >= 0) w_gap = c - last;
            last = c;
            w_ticks++;
         end
      end
   endtask

   task automatic wait_tick(input int lim, input string nm);
      bit got;
      got = 1'b0;
      for (int c = 0; c < lim && !got; c++) begin
         @(negedge clk);
         if (period_tick) got = 1'b1;
      end
      check(nm, 32'(got), 32'd1);
   endtask

   task automatic wait_count(input int val, input int lim, input string nm);
      bit got;
      got = 1'b0;
      for (int c = 0; c < lim && !got; c++) begin
         @(negedge clk);
         if (int'(counter) == val) got = 1'b1;
      end
      check(nm, 32'(got), 32'd1);
   endtask

   task automatic do_load(input int per, input int psc, input int d0, input int d1,
                          input int d2, input int d3);
      @(negedge clk);
      period    = CW'(per);
      prescaler = CW'(psc);
      duty      = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_cnt", 32'(counter), 32'd0);
      check("rst_pend", 32'(load_pending), 32'd0);

      // Basic run: duties 0/25/50/100 of a 100-count period.
      do_load(100, 1, 0, 25, 50, 100);
      check("dis_load_pend", 32'(load_pending), 32'd0);
      enable = 1'b1;
      wait_tick(300, "basic_first_tick");
      window(200);
      check("basic_ch0", 32'(w_hi[0]), 32'd0);
      check("basic_ch1", 32'(w_hi[1]), 32'd50);
      check("basic_ch2", 32'(w_hi[2]), 32'd100);
      check("basic_ch3", 32'(w_hi[3]), 32'd200);
      check("basic_ticks", 32'(w_ticks), 32'd2);
      check("basic_gap", 32'(w_gap), 32'd100);

      // Shadow update mid-period.
      repeat (30) @(negedge clk);
      duty[1*CW +: CW] = CW'(75);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("shadow_pend_hi", 32'(load_pending), 32'd1);
      wait_tick(200, "shadow_tick");
      check("shadow_pend_lo", 32'(load_pending), 32'd0);
      window(100);
      check("shadow_ch1", 32'(w_hi[1]), 32'd75);

      // Prescaler 3, period 10.
      @(negedge clk);
      enable = 1'b0;
      do_load(10, 3, 0, 3, 5, 10);
      enable = 1'b1;
      wait_tick(100, "psc_first_tick");
      window(90);
      check("psc_ticks", 32'(w_ticks), 32'd3);
      check("psc_gap", 32'(w_gap), 32'd30);
      check("psc_ch1", 32'(w_hi[1]), 32'd27);
      check("psc_ch2", 32'(w_hi[2]), 32'd45);

      // Zero period while disabled, then enabled.
      @(negedge clk);
      enable = 1'b0;
      do_load(0, 1, 5, 5, 5, 5);
      check("zero_pend", 32'(load_pending), 32'd0);
      check("zero_pwm", 32'(pwm_out), 32'd0);
      enable = 1'b1;
      window(50);
      check("zero_ticks", 32'(w_ticks), 32'd0);
      check("zero_ch0", 32'(w_hi[0]), 32'd0);

      // Reset mid-operation with a load pending.
      enable = 1'b0;
      do_load(100, 1, 10, 40, 60, 90);
      enable = 1'b1;
      wait_count(50, 300, "rst_reach50");
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_count(57, 50, "rst_reach57");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_cnt", 32'(counter), 32'd0);
      check("midrst_pwm", 32'(pwm_out), 32'd0);
      check("midrst_pend", 32'(load_pending), 32'd0);
      check("midrst_tick", 32'(period_tick), 32'd0);
      window(20);
      check("midrst_hold_ch3", 32'(w_hi[3]), 32'd0);
      check("midrst_hold_ticks", 32'(w_ticks), 32'd0);

      // Randomised traffic checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         load  = 1'b0;
         reset = 1'b0;
         if ($urandom_range(0, 19) == 0) begin
            period    = CW'($urandom_range(0, 12));
            prescaler = CW'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++) duty[i*CW +: CW] = CW'($urandom_range(0, 14));
            load = 1'b1;
         end
         if ($urandom_range(0, 59) == 0) enable = (enable == 1'b1) ? ($urandom_range(0, 3) == 0) : 1'b1;
         if ($urandom_range(0, 499) == 0) reset = 1'b1;
      end
      @(negedge clk);
      load  = 1'b0;
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
